// File: rtl/cca_pkg.sv
// Shared constants for the chromatic-adaptation path: coefficient format, identity matrix,
// and coefficient slice indices used by both the matrix generator and the apply stage.
package cca_pkg;

  localparam int CCA_PIX_W  = 8;
  localparam int CCA_COEF_W = 32;
  localparam int FRAC_BITS  = 16;

  localparam logic [CCA_COEF_W-1:0] FP_ONE = 32'h0001_0000;

  // Row-major coefficient index; m00 sits in the lowest slice of the packed matrix.
  localparam int M00 = 0;
  localparam int M01 = 1;
  localparam int M02 = 2;
  localparam int M10 = 3;
  localparam int M11 = 4;
  localparam int M12 = 5;
  localparam int M20 = 6;
  localparam int M21 = 7;
  localparam int M22 = 8;

  localparam logic [9*CCA_COEF_W-1:0] IDENTITY_MATRIX = {
    FP_ONE, 32'd0, 32'd0,
    32'd0, FP_ONE, 32'd0,
    32'd0, 32'd0, FP_ONE
  };

  function automatic int coef_lsb(input int row, input int col);
    return (row * 3 + col) * CCA_COEF_W;
  endfunction

endpackage

// File: rtl/color_matrix_apply_if.sv
// Matrix load port and pixel in/out streams of the colour-matrix apply stage.
interface color_matrix_apply_if
  import cca_pkg::*;
#(
  parameter int PIX_W  = cca_pkg::CCA_PIX_W,
  parameter int COEF_W = cca_pkg::CCA_COEF_W
);

  logic [9*COEF_W-1:0] comp_matrix;
  logic                matrix_valid;
  logic [3*PIX_W-1:0]  pix_in;
  logic                pix_sof;
  logic                pix_valid;
  logic                pix_ready;
  logic [3*PIX_W-1:0]  pix_out;
  logic                out_sof;
  logic                out_valid;
  logic                out_ready;
  logic                mat_pending;

  modport master (
    output comp_matrix, matrix_valid, pix_in, pix_sof, pix_valid, out_ready,
    input  pix_ready, pix_out, out_sof, out_valid, mat_pending
  );

  modport slave (
    input  comp_matrix, matrix_valid, pix_in, pix_sof, pix_valid, out_ready,
    output pix_ready, pix_out, out_sof, out_valid, mat_pending
  );

endinterface

// File: rtl/cca_dot3.sv
// Three-term signed dot product of coefficients with unsigned channels:
// products registered in the first stage, row sum registered in the second.
module cca_dot3
  import cca_pkg::*;
#(
  parameter int PIX_W  = cca_pkg::CCA_PIX_W,
  parameter int COEF_W = cca_pkg::CCA_COEF_W,
  localparam int PROD_W = COEF_W + PIX_W + 1,
  localparam int SUM_W  = PROD_W + 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [3*COEF_W-1:0]      coefs,
  input  logic [3*PIX_W-1:0]       chans,
  output logic signed [SUM_W-1:0]  sum
);

  logic signed [PROD_W-1:0] prod [3];

  // Channels are zero-extended by one bit so they multiply as non-negative signed values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) prod[i] <= '0;
      sum <= '0;
    end else if (en) begin
      for (int i = 0; i < 3; i++) begin
        prod[i] <= PROD_W'($signed(coefs[i*COEF_W +: COEF_W]))
                 * PROD_W'($signed({1'b0, chans[i*PIX_W +: PIX_W]}));
      end
      sum <= SUM_W'(prod[0]) + SUM_W'(prod[1]) + SUM_W'(prod[2]);
    end
  end

endmodule

// File: rtl/color_matrix_apply.sv
// Applies a double-buffered 3x3 fixed-point matrix to an RGB stream, swapping matrices at SOF.
// Define CCA_ROUND_EN for round-half-up before the fractional shift; default truncates.
module color_matrix_apply
  import cca_pkg::*;
#(
  parameter int PIX_W     = cca_pkg::CCA_PIX_W,
  parameter int COEF_W    = cca_pkg::CCA_COEF_W,
  parameter int FRAC_BITS = cca_pkg::FRAC_BITS
) (
  input logic             clk,
  input logic             rst_n,
  color_matrix_apply_if.slave bus
);

  localparam int PROD_W = COEF_W + PIX_W + 1;
  localparam int SUM_W  = PROD_W + 2;

  function automatic logic [9*COEF_W-1:0] identity_matrix();
    logic [9*COEF_W-1:0] m;
    m = '0;
    for (int i = 0; i < 3; i++) m[(i*4)*COEF_W +: COEF_W] = COEF_W'(1) << FRAC_BITS;
    return m;
  endfunction

  localparam logic [9*COEF_W-1:0]      IDENT   = identity_matrix();
  localparam logic signed [SUM_W-1:0]  PIX_MAX = SUM_W'((1 << PIX_W) - 1);
`ifdef CCA_ROUND_EN
  localparam logic signed [SUM_W-1:0]  ROUND   = SUM_W'(1) << (FRAC_BITS - 1);
`else
  localparam logic signed [SUM_W-1:0]  ROUND   = '0;
`endif

  logic [9*COEF_W-1:0]     active_m;
  logic [9*COEF_W-1:0]     shadow_m;
  logic                    pending_q;
  logic                    v1, v2, sof1, sof2;
  logic                    out_valid_q, out_sof_q;
  logic [3*PIX_W-1:0]      pix_out_q;
  logic [3*PIX_W-1:0]      next_pix;
  logic signed [SUM_W-1:0] row_sum [3];
  logic signed [SUM_W-1:0] shifted;
  logic                    adv, swap_gate, do_swap, pix_ready_c, accept;

  // A pending matrix holds the SOF beat off until every stage has drained.
  assign adv         = !out_valid_q || bus.out_ready;
  assign swap_gate   = bus.pix_valid && bus.pix_sof && pending_q;
  assign do_swap     = swap_gate && !v1 && !v2 && !out_valid_q;
  assign pix_ready_c = adv && !swap_gate && rst_n;
  assign accept      = bus.pix_valid && pix_ready_c;

  assign bus.pix_ready   = pix_ready_c;
  assign bus.pix_out     = pix_out_q;
  assign bus.out_sof     = out_sof_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.mat_pending = pending_q;

  // A strobe coincident with a swap lands in shadow after the swap has taken the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_m  <= IDENT;
      shadow_m  <= IDENT;
      pending_q <= 1'b0;
    end else begin
      if (do_swap) active_m <= shadow_m;
      if (bus.matrix_valid) begin
        shadow_m  <= bus.comp_matrix;
        pending_q <= 1'b1;
      end else if (do_swap) begin
        pending_q <= 1'b0;
      end
    end
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    cca_dot3 #(
      .PIX_W  (PIX_W),
      .COEF_W (COEF_W)
    ) u_dot (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .coefs (active_m[r*3*COEF_W +: 3*COEF_W]),
      .chans (bus.pix_in),
      .sum   (row_sum[r])
    );
  end

  always_comb begin
    next_pix = '0;
    shifted  = '0;
    for (int r = 0; r < 3; r++) begin
      shifted = (row_sum[r] + ROUND) >>> FRAC_BITS;
      if (shifted[SUM_W-1])       next_pix[r*PIX_W +: PIX_W] = '0;
      else if (shifted > PIX_MAX) next_pix[r*PIX_W +: PIX_W] = '1;
      else                        next_pix[r*PIX_W +: PIX_W] = shifted[PIX_W-1:0];
    end
  end

  // Valid and SOF flags ride alongside the data; bubbles shift through rather than collapse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      sof1        <= 1'b0;
      sof2        <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      pix_out_q   <= '0;
    end else if (adv) begin
      v1          <= accept;
      sof1        <= accept && bus.pix_sof;
      v2          <= v1;
      sof2        <= sof1;
      out_valid_q <= v2;
      out_sof_q   <= sof2;
      pix_out_q   <= next_pix;
    end
  end

endmodule

// File: tb/tb_color_matrix_apply.sv
// Scoreboard bench for color_matrix_apply: directed matrix/swap cases, a randomised
// back-pressure run against an arithmetic reference model, and a mid-flight reset.
module tb_color_matrix_apply;

  logic clk;
  logic rst_n;

  color_matrix_apply_if bus ();

  color_matrix_apply dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [24:0]  exp_q[$];
  logic [287:0] m_active, m_shadow;
  bit           m_pending;
  bit           rand_ready = 0;
  bit           hold_pending = 0;
  logic [25:0]  held;

  function automatic logic [23:0] model_pixel(input logic [287:0] m, input logic [23:0] p);
    logic [23:0] res;
    longint      acc;
    res = '0;
    for (int r = 0; r < 3; r++) begin
      acc = 0;
      for (int c = 0; c < 3; c++)
        acc += longint'($signed(m[(r*3+c)*32 +: 32])) * longint'(p[c*8 +: 8]);
`ifdef CCA_ROUND_EN
      acc += 64'sd32768;
`endif
      acc = acc >>> 16;
      if (acc < 0)        res[r*8 +: 8] = 8'd0;
      else if (acc > 255) res[r*8 +: 8] = 8'd255;
      else                res[r*8 +: 8] = acc[7:0];
    end
    return res;
  endfunction

  function automatic logic [287:0] diag(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
    return {a, 32'd0, 32'd0, 32'd0, b, 32'd0, 32'd0, 32'd0, c};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    m_active  = diag(32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    m_shadow  = m_active;
    m_pending = 0;
  endtask

  // Called just after a rising edge, with no beat being presented.
  task automatic applyMatrix(input logic [287:0] m);
    bus.comp_matrix  = m;
    bus.matrix_valid = 1'b1;
    m_shadow  = m;
    m_pending = 1;
    @(posedge clk); #1;
    bus.matrix_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [23:0] pix, input logic sof, input bit use_exp,
                               input logic [23:0] exp_pix, output bit ready_first);
    bit accepted;
    int waited;
    accepted    = 0;
    waited      = 0;
    ready_first = 0;
    bus.pix_in    = pix;
    bus.pix_sof   = sof;
    bus.pix_valid = 1'b1;
    while (!accepted && waited < 200) begin
      @(negedge clk);
      if (waited == 0) ready_first = bus.pix_ready;
      if (bus.pix_ready) begin
        if (sof && m_pending) begin
          m_active  = m_shadow;
          m_pending = 0;
        end
        exp_q.push_back({sof, use_exp ? exp_pix : model_pixel(m_active, pix)});
        accepted = 1;
      end
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("beat_accepted", 64'(accepted), 64'd1);
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor: pops on each handshake, and checks outputs stay put while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 0;
    end else begin
      if (hold_pending) begin
        checkOutput("stall_hold", 64'({bus.out_valid, bus.out_sof, bus.pix_out}), 64'(held));
        hold_pending = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_out: got %h, expected no beat", bus.pix_out);
        end else begin
          checkOutput("out_beat", 64'({bus.out_sof, bus.pix_out}), 64'(exp_q.pop_front()));
        end
      end else if (bus.out_valid) begin
        held         = {bus.out_valid, bus.out_sof, bus.pix_out};
        hold_pending = 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      bus.out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit         rf;
    logic [23:0] p;
    logic [31:0] cf [9];
    logic [287:0] rm;

    rst_n            = 1'b0;
    bus.comp_matrix  = '0;
    bus.matrix_valid = 1'b0;
    bus.pix_in       = '0;
    bus.pix_sof      = 1'b0;
    bus.pix_valid    = 1'b1;
    bus.out_ready    = 1'b1;
    modelReset();

    @(negedge clk);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_pix_out", 64'(bus.pix_out), 64'd0);
    checkOutput("rst_out_sof", 64'(bus.out_sof), 64'd0);
    checkOutput("rst_mat_pending", 64'(bus.mat_pending), 64'd0);
    checkOutput("rst_pix_ready", 64'(bus.pix_ready), 64'd0);
    bus.pix_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] identity after reset");
    applyStimulus({8'd30, 8'd20, 8'd10}, 1'b1, 1, {8'd30, 8'd20, 8'd10}, rf);

    $display("[TB] diag 1.5 at next SOF");
    applyMatrix(diag(32'h0001_8000, 32'h0001_8000, 32'h0001_8000));
    @(negedge clk);
    checkOutput("pending_set", 64'(bus.mat_pending), 64'd1);
    @(posedge clk); #1;
`ifdef CCA_ROUND_EN
    applyStimulus({8'd255, 8'd100, 8'd3}, 1'b1, 1, {8'd255, 8'd150, 8'd5}, rf);
`else
    applyStimulus({8'd255, 8'd100, 8'd3}, 1'b1, 1, {8'd255, 8'd150, 8'd4}, rf);
`endif

    $display("[TB] negative coefficient clamp");
    applyMatrix(diag(32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000));
    applyStimulus({8'd9, 8'd7, 8'd200}, 1'b1, 1, {8'd9, 8'd7, 8'd0}, rf);
    waitDrain();

    $display("[TB] mid-frame matrix update");
    applyMatrix(diag(32'h0001_0000, 32'h0001_0000, 32'h0001_0000));
    applyStimulus({8'd70, 8'd60, 8'd50}, 1'b1, 1, {8'd70, 8'd60, 8'd50}, rf);
    applyStimulus({8'd11, 8'd22, 8'd33}, 1'b0, 0, '0, rf);
    applyMatrix(diag(32'h0002_0000, 32'h0001_0000, 32'h0000_8000));
    applyStimulus({8'd40, 8'd40, 8'd40}, 1'b0, 1, {8'd40, 8'd40, 8'd40}, rf);
    applyStimulus({8'd90, 8'd80, 8'd70}, 1'b0, 1, {8'd90, 8'd80, 8'd70}, rf);
    checkOutput("pending_midframe", 64'(bus.mat_pending), 64'd1);
    applyStimulus({8'd40, 8'd40, 8'd40}, 1'b1, 1, {8'd80, 8'd40, 8'd20}, rf);
    checkOutput("sof_gated", 64'(rf), 64'd0);
    @(negedge clk);
    checkOutput("pending_cleared", 64'(bus.mat_pending), 64'd0);
    @(posedge clk); #1;
    applyStimulus({8'd10, 8'd10, 8'd10}, 1'b0, 1, {8'd20, 8'd10, 8'd5}, rf);
    waitDrain();

    $display("[TB] randomised back-pressure run");
    rand_ready = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        for (int k = 0; k < 9; k++)
          cf[k] = 32'($urandom_range(0, 32'h0004_0000)) - 32'h0002_0000;
        rm = {cf[8], cf[7], cf[6], cf[5], cf[4], cf[3], cf[2], cf[1], cf[0]};
        applyMatrix(rm);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      p = 24'($urandom());
      applyStimulus(p, (i == 0) || ($urandom_range(0, 39) == 0), 0, '0, rf);
    end
    rand_ready = 0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    waitDrain();

    $display("[TB] reset with beats in flight");
    applyMatrix(diag(32'h0002_0000, 32'h0002_0000, 32'h0002_0000));
    applyStimulus({8'd30, 8'd20, 8'd10}, 1'b1, 0, '0, rf);
    applyStimulus({8'd1, 8'd2, 8'd3}, 1'b0, 0, '0, rf);
    applyStimulus({8'd4, 8'd5, 8'd6}, 1'b0, 0, '0, rf);
    applyStimulus({8'd7, 8'd8, 8'd9}, 1'b0, 0, '0, rf);
    checkOutput("flight_out_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    exp_q.delete();
    modelReset();
    #1;
    checkOutput("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("midrst_pix_out", 64'(bus.pix_out), 64'd0);
    checkOutput("midrst_pix_ready", 64'(bus.pix_ready), 64'd0);
    checkOutput("midrst_pending", 64'(bus.mat_pending), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus({8'd30, 8'd20, 8'd10}, 1'b1, 1, {8'd30, 8'd20, 8'd10}, rf);
    applyStimulus({8'd255, 8'd0, 8'd128}, 1'b0, 1, {8'd255, 8'd0, 8'd128}, rf);
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
